cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Parametrised common-data-bus arbiter for the out-of-order core. It accepts results from `NUM_SRC` execution units (ALU, branch ALU, load/store and any future units), holding at most one result per unit in a staging slot. Each cycle it grants one occupied slot by round-robin and broadcasts that result, registered, to the reservation stations, the ROB and the PC. Compared with the fixed three-source combinational bus, it adds a configurable source count, fairness, per-source buffering, registered broadcast and an optional flush.

## Interface
Parameters:
- `NUM_SRC`, 3, number of producer units (2..8)
- `IDX_W`, 5, ROB tag width; tag 0 means "no result"
- `DATA_W`, 32, result width
- `ADDR_W`, 32, address/next-PC field width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, **synchronous, active-low**
- `src_valid`  in  NUM_SRC  per-source result present this cycle
- `src_ready`  out  NUM_SRC  per-source slot can accept this cycle
- `src_index`  in  NUM_SRC*IDX_W  flattened ROB tags
- `src_data`  in  NUM_SRC*DATA_W  flattened results
- `src_addr`  in  NUM_SRC*ADDR_W  flattened address/target
- `src_is_branch`  in  NUM_SRC  result is a resolved branch
- `flush`  in  1  discard all staged results (present only with `CDB_FLUSH_EN`)
- `cdb_valid`  out  1  broadcast valid
- `cdb_index`  out  IDX_W  broadcast tag, 0 when not valid
- `cdb_data`  out  DATA_W  broadcast value
- `cdb_addr`  out  ADDR_W  broadcast address
- `cdb_is_branch`  out  1  broadcast is a branch
- `cdb_src`  out  $clog2(NUM_SRC)  id of the granted source

## Operation
- Each source i has a staging slot: occupied flag `occ[i]` plus a payload register.
- `src_ready[i] = !occ[i] | gnt[i]` (combinational). A slot being granted this cycle can be refilled in the same cycle.
- Transfer: `src_valid[i] & src_ready[i]` at a clock edge sets `occ[i]` and loads the payload. `src_valid` while not ready is a protocol error; the input is ignored and the source must hold it.
- Arbitration is combinational over `occ`. `gnt` is one-hot, or zero if no slot is occupied. Search starts at pointer `rr`, ascending modulo NUM_SRC.
- On a grant:
  - the granted payload loads the output register;
  - `occ[g]` clears unless it is refilled in the same cycle;
  - `rr` becomes (g+1) mod NUM_SRC.
- With no grant, `rr` holds and `cdb_valid` goes low next cycle.
- Fairness: a continuously occupied slot is granted within NUM_SRC cycles.
- Slots with a tag equal to 0 are never loaded; such a `src_valid` is dropped.

## Timing
- Reset (`rst`=0 at an edge):
  - `occ`=0 and `rr`=0;
  - `cdb_valid`=0, `cdb_index`=0, `cdb_data`=0, `cdb_addr`=0, `cdb_is_branch`=0, `cdb_src`=0;
  - `src_ready` is all-ones after the edge.
- Latency: a result accepted at edge N is visible on `cdb_*` after edge N+1 at the earliest, i.e. 1 cycle of staging plus 1 of output register.
- `cdb_valid` is high for exactly one cycle per broadcast. Back-to-back broadcasts from different sources are allowed, one per cycle.
- Sustained throughput is 1 result per cycle in total. A single source can also sustain 1 per cycle by using the same-cycle refill.
- When all slots are occupied, grants rotate strictly: rr, rr+1, and so on.
- Reset mid-operation discards all staged results and the pending output.

## Configuration
- `CDB_FLUSH_EN` defined:
  - the `flush` port exists;
  - `flush`=1 at an edge clears `occ`, forces `cdb_valid`=0 and `cdb_index`=0 next cycle, and keeps `rr`;
  - loads in the flush cycle are discarded;
  - `src_ready` is unaffected.
- Not defined: there is no `flush` port, and staged results are drained normally.

## Structure
- The shared package `cdb_pkg` holds:
  - default widths (`IDX_W`, `DATA_W`, `ADDR_W`);
  - the broadcast payload typedef (index, data, addr, is_branch);
  - the null tag constant 0.
- Sub-module `rr_arbiter`: parametrised on NUM_SRC; inputs are the request vector and `rr`; outputs are the one-hot grant and the encoded id. It is purely combinational; `rr` lives in the parent.

## Test plan
- Reset, then source 0 sends valid tag 5, data 0x1234 at edge 1 → `cdb_valid`=1, `cdb_index`=5, `cdb_data`=0x1234, `cdb_src`=0 after edge 2, low after edge 3.
- All 3 sources valid in the same cycle with tags 1/2/3, `rr`=0 → broadcasts tags 1, 2, 3 on consecutive cycles, then `rr`=0.
- Source 1 streams tags 4, 5, 6 on consecutive cycles, alone → `src_ready[1]` stays 1 and tags 4, 5, 6 are broadcast on consecutive cycles.
- Sources 0 and 2 held permanently occupied by refills → grants alternate 0, 2, 0, 2; neither waits more than NUM_SRC cycles.
- `CDB_FLUSH_EN`: two slots occupied, `flush`=1 → no broadcast follows, `occ`=0, and a later tag 7 from source 2 is broadcast normally.
- `rst`=0 asserted while two slots are occupied and `cdb_valid`=1 → all outputs are 0 after the edge and no stale tags appear afterwards.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared default widths, broadcast payload type and null tag
// used by the common-data-bus arbiter and its users.
package cdb_pkg;
    localparam int CDB_IDX_W  = 5;
    localparam int CDB_DATA_W = 32;
    localparam int CDB_ADDR_W = 32;
    localparam logic [CDB_IDX_W-1:0] NULL_TAG = '0;
    typedef struct packed {
        logic [CDB_IDX_W-1:0]  index;
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_ADDR_W-1:0] addr;
        logic                  is_branch;
    } cdb_payload_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant over a request vector,
// searching upward from the pointer rr held by the parent.
module rr_arbiter #(
    parameter int NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] rr,
    output logic [NUM_SRC-1:0]         gnt,
    output logic [$clog2(NUM_SRC)-1:0] id
);
    localparam int SW = $clog2(NUM_SRC);
    logic [SW-1:0] j;
    // Walk from the farthest offset back to rr so the nearest request wins.
    always_comb begin
        gnt = '0;
        id  = '0;
        j   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = SW'((int'(rr) + k) % NUM_SRC);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                id     = j;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common-data-bus arbiter with one staging slot per
// source and a registered broadcast. Define CDB_FLUSH_EN to add the flush port.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = CDB_IDX_W,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int ADDR_W  = CDB_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [NUM_SRC*IDX_W-1:0]     src_index,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    input  logic [NUM_SRC*ADDR_W-1:0]    src_addr,
    input  logic [NUM_SRC-1:0]           src_is_branch,
`ifdef CDB_FLUSH_EN
    input  logic                         flush,
`endif
    output logic                         cdb_valid,
    output logic [IDX_W-1:0]             cdb_index,
    output logic [DATA_W-1:0]            cdb_data,
    output logic [ADDR_W-1:0]            cdb_addr,
    output logic                         cdb_is_branch,
    output logic [$clog2(NUM_SRC)-1:0]   cdb_src
);
    localparam int SW = $clog2(NUM_SRC);
    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              is_branch;
    } payload_t;
    logic [NUM_SRC-1:0] occ, gnt, load;
    logic [SW-1:0] rr, g;
    logic kill, fire;
    payload_t pl_in [NUM_SRC];
    payload_t slot [NUM_SRC];
    payload_t out;
`ifdef CDB_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif
    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req(occ),
        .rr (rr),
        .gnt(gnt),
        .id (g)
    );
    assign fire      = |gnt & ~kill;
    assign src_ready = ~occ | gnt;
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pl_in[i] = '{index: src_index[i*IDX_W +: IDX_W], data: src_data[i*DATA_W +: DATA_W],
                         addr: src_addr[i*ADDR_W +: ADDR_W], is_branch: src_is_branch[i]};
            load[i]  = src_valid[i] & src_ready[i] & (src_index[i*IDX_W +: IDX_W] != IDX_W'(NULL_TAG));
        end
    end
    // A granted slot that is refilled in the same cycle stays occupied.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ       <= '0;
            rr        <= '0;
            cdb_valid <= 1'b0;
            out       <= '0;
            cdb_src   <= '0;
        end else begin
            occ <= kill ? '0 : (occ & ~gnt) | load;
            for (int i = 0; i < NUM_SRC; i++)
                if (load[i]) slot[i] <= pl_in[i];
            if (fire) rr <= (g == SW'(NUM_SRC - 1)) ? '0 : g + 1'b1;
            cdb_valid <= fire;
            out       <= fire ? slot[g] : '0;
            cdb_src   <= fire ? g : '0;
        end
    end
    assign cdb_index     = out.index;
    assign cdb_data      = out.data;
    assign cdb_addr      = out.addr;
    assign cdb_is_branch = out.is_branch;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a
// slot/round-robin reference model. Honours CDB_FLUSH_EN like the design.
module tb_cdb_arbiter;
    import cdb_pkg::*;
    localparam int N  = 3;
    localparam int IW = CDB_IDX_W;
    localparam int DW = CDB_DATA_W;
    localparam int AW = CDB_ADDR_W;
    localparam int SW = $clog2(N);
    logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic [N-1:0] src_valid = '0, src_is_branch = '0, src_ready;
    logic [N*IW-1:0] src_index = '0;
    logic [N*DW-1:0] src_data = '0;
    logic [N*AW-1:0] src_addr = '0;
    logic cdb_valid, cdb_is_branch;
    logic [IW-1:0] cdb_index;
    logic [DW-1:0] cdb_data;
    logic [AW-1:0] cdb_addr;
    logic [SW-1:0] cdb_src;
    int checks = 0, errors = 0;
    bit m_occ[N];
    cdb_payload_t m_slot[N];
    int m_rr = 0;
    bit e_valid = 0;
    cdb_payload_t e_out = '0;
    int e_src = 0;
    bit pend[N];
    always #5 clk = ~clk;
    cdb_arbiter #(.NUM_SRC(N)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_index(src_index), .src_data(src_data), .src_addr(src_addr),
        .src_is_branch(src_is_branch),
`ifdef CDB_FLUSH_EN
        .flush(flush),
`endif
        .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_data(cdb_data),
        .cdb_addr(cdb_addr), .cdb_is_branch(cdb_is_branch), .cdb_src(cdb_src)
    );
    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction
    // First occupied slot at or after the pointer, wrapping; -1 when idle.
    function automatic int m_grant();
        for (int k = 0; k < N; k++)
            if (m_occ[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction
    function automatic bit m_ready(int i);
        return !m_occ[i] || m_grant() == i;
    endfunction
    task automatic drv(int i, bit v, logic [IW-1:0] t, logic [DW-1:0] d);
        src_valid[i] = v;
        src_index[i*IW +: IW] = t;
        src_data[i*DW +: DW] = d;
        src_addr[i*AW +: AW] = d ^ 32'hA5A5_0F0F;
        src_is_branch[i] = t[0];
    endtask
    task automatic tick();
        int g;
        bit fl;
        bit acc[N];
        logic [N-1:0] er;
        g = m_grant();
        fl = flush;
        for (int i = 0; i < N; i++)
            acc[i] = src_valid[i] && m_ready(i) && src_index[i*IW +: IW] != NULL_TAG && !fl;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < N; i++) m_occ[i] = 0;
            m_rr = 0;
            e_valid = 0;
            e_out = '0;
            e_src = 0;
        end else begin
            e_valid = (g >= 0) && !fl;
            e_out = '0;
            e_src = 0;
            if (e_valid) begin
                e_out = m_slot[g];
                e_src = g;
                m_rr = (g + 1) % N;
            end
            if (g >= 0) m_occ[g] = 0;
            if (fl) for (int i = 0; i < N; i++) m_occ[i] = 0;
            for (int i = 0; i < N; i++)
                if (acc[i]) begin
                    m_occ[i] = 1;
                    m_slot[i] = '{index: src_index[i*IW +: IW], data: src_data[i*DW +: DW],
                                  addr: src_addr[i*AW +: AW], is_branch: src_is_branch[i]};
                end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) er[i] = m_ready(i);
        chk("ready", src_ready, er);
        chk("valid", cdb_valid, e_valid);
        chk("index", cdb_index, e_out.index);
        if (e_valid) begin
            chk("data", cdb_data, e_out.data);
            chk("addr", cdb_addr, e_out.addr);
            chk("branch", cdb_is_branch, e_out.is_branch);
            chk("src", cdb_src, e_src);
        end
    endtask
    task automatic do_reset();
        src_valid = '0;
        flush = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask
    initial begin
        bit acc[N];
        int pv;
        // Reset state and single-result latency.
        do_reset();
        chk("rst_valid", cdb_valid, 0);
        chk("rst_index", cdb_index, 0);
        chk("rst_data", cdb_data, 0);
        chk("rst_src", cdb_src, 0);
        chk("rst_ready", src_ready, 3'b111);
        drv(0, 1, 5, 32'h1234);
        tick();
        drv(0, 0, 0, 0);
        chk("lat_e1_valid", cdb_valid, 0);
        tick();
        chk("lat_e2_valid", cdb_valid, 1);
        chk("lat_e2_index", cdb_index, 5);
        chk("lat_e2_data", cdb_data, 32'h1234);
        chk("lat_e2_src", cdb_src, 0);
        tick();
        chk("lat_e3_valid", cdb_valid, 0);
        // All three at once from rr=0, then again to confirm rr wrapped to 0.
        do_reset();
        for (int i = 0; i < N; i++) drv(i, 1, IW'(i + 1), 32'(100 + i));
        tick();
        src_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("all3_index", cdb_index, k);
        end
        for (int i = 0; i < N; i++) drv(i, 1, IW'(i + 4), 32'(200 + i));
        tick();
        src_valid = '0;
        tick();
        chk("wrap_index", cdb_index, 4);
        tick();
        tick();
        // Single source streaming through same-cycle refill.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                chk("stream_ready", src_ready[1], 1);
                drv(1, 1, IW'(4 + k), 32'(k));
            end else drv(1, 0, 0, 0);
            tick();
            if (k > 0) chk("stream_index", cdb_index, 4 + k - 1);
        end
        // Sources 0 and 2 kept occupied alternate grants.
        do_reset();
        drv(0, 1, 1, 32'h100);
        drv(2, 1, 2, 32'h200);
        tick();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < N; i += 2)
                if (m_ready(i)) drv(i, 1, IW'(10 + 2 * n + i / 2), 32'(n));
            tick();
            chk("alt_valid", cdb_valid, 1);
            chk("alt_src", cdb_src, (n % 2 == 0) ? 0 : 2);
        end
        src_valid = '0;
        tick();
        tick();
`ifdef CDB_FLUSH_EN
        do_reset();
        drv(0, 1, 1, 32'h11);
        drv(1, 1, 2, 32'h22);
        tick();
        src_valid = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", cdb_valid, 0);
        chk("flush_index", cdb_index, 0);
        chk("flush_ready", src_ready, 3'b111);
        tick();
        chk("flush_after_valid", cdb_valid, 0);
        drv(2, 1, 7, 32'h77);
        tick();
        src_valid = '0;
        tick();
        chk("flush_t7_valid", cdb_valid, 1);
        chk("flush_t7_index", cdb_index, 7);
        chk("flush_t7_src", cdb_src, 2);
`endif
        // Reset mid-operation with a live broadcast and an occupied slot.
        do_reset();
        drv(0, 1, 8, 32'h88);
        drv(1, 1, 9, 32'h99);
        tick();
        src_valid = '0;
        tick();
        chk("mid_pre_valid", cdb_valid, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_valid", cdb_valid, 0);
        chk("mid_index", cdb_index, 0);
        chk("mid_data", cdb_data, 0);
        chk("mid_addr", cdb_addr, 0);
        chk("mid_branch", cdb_is_branch, 0);
        chk("mid_src", cdb_src, 0);
        chk("mid_ready", src_ready, 3'b111);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_stale_valid", cdb_valid, 0);
        end
        // Randomized traffic; sources hold their result until accepted.
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            pv = (c < 2000) ? 60 : 100;
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 99) < pv) begin
                    pend[i] = 1;
                    drv(i, 1, IW'($urandom_range(0, 31)), $urandom);
                end
            rst = ($urandom_range(0, 199) != 0);
`ifdef CDB_FLUSH_EN
            flush = ($urandom_range(0, 19) == 0);
`endif
            for (int i = 0; i < N; i++) acc[i] = pend[i] && m_ready(i);
            tick();
            for (int i = 0; i < N; i++)
                if (acc[i]) begin
                    pend[i] = 0;
                    src_valid[i] = 1'b0;
                end
        end
        rst = 1'b1;
        flush = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
